// File: rtl/median_window_3x3_pkg.sv
// Shared definitions for the median-filter window and sort stages.
package median_window_3x3_pkg;

   // Default pixel width in bits.
   localparam int unsigned MW_DW = 8;

   // Accepted pixel to window output, in clock cycles; the sort stage uses this to align sideband signals.
   localparam int unsigned LATENCY = 2;

   // 3x3 neighbourhood, indexed [row][col] with row 2 = top and col 2 = left.
   typedef logic [2:0][2:0][MW_DW-1:0] window_t;

   // Frame-tracking FSM state encoding.
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACTIVE = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

endpackage

// File: rtl/median_line_buffer.sv
// One image line of storage: simple dual-port RAM, registered read, read-before-write.
module median_line_buffer
   import median_window_3x3_pkg::*;
#(
   parameter int unsigned DW    = MW_DW,
   parameter int unsigned DEPTH = 640,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [DEPTH];

   // Storage array; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read; a same-address write in the same cycle returns the old word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/median_window_3x3.sv
// Raster-stream 3x3 window generator feeding the row-wise median sorters.
module median_window_3x3
   import median_window_3x3_pkg::*;
#(
   parameter int unsigned DW    = MW_DW,
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic            in_sof,
   input  logic [DW-1:0]   in_data,
   output logic            out_valid,
   output logic            out_sof,
   output logic            out_border,
   output logic [3*DW-1:0] out_row_top,
   output logic [3*DW-1:0] out_row_mid,
   output logic [3*DW-1:0] out_row_bot
);

   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = $clog2(IMG_H);

   logic [1:0]    state, state_next;
   logic [CW-1:0] col, col_next, pix_col;
   logic [RW-1:0] row, row_next, pix_row;
   logic          accept;

   logic          s1_valid, s1_sof;
   logic [CW-1:0] s1_col;
   logic [RW-1:0] s1_row;
   logic [DW-1:0] s1_data;

   logic [DW-1:0] line_a, line_b;

   // Column shift registers, index 2 = top, 1 = mid, 0 = bottom.
   logic [2:0][DW-1:0] col0, col1, col2;
   logic               top_ok, mid_ok, c1_ok, c2_ok;

   // Frame state and raster position registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         row   <= '0;
         col   <= '0;
      end else begin
         state <= state_next;
         row   <= row_next;
         col   <= col_next;
      end
   end

   // Pixel acceptance, coordinate assignment and frame transitions; sof always restarts at (0,0).
   always_comb begin
      state_next = state;
      row_next   = row;
      col_next   = col;
      accept     = 1'b0;
      pix_row    = row;
      pix_col    = col;
      if (in_valid && in_sof) begin
         accept  = 1'b1;
         pix_row = '0;
         pix_col = '0;
      end else if (in_valid && (state == ACTIVE)) begin
         accept = 1'b1;
      end
      if (accept) begin
         state_next = ACTIVE;
         if (pix_col == CW'(IMG_W - 1)) begin
            col_next = '0;
            if (pix_row == RW'(IMG_H - 1)) begin
               row_next   = '0;
               state_next = DONE;
            end else begin
               row_next = pix_row + RW'(1);
            end
         end else begin
            col_next = pix_col + CW'(1);
            row_next = pix_row;
         end
      end
   end

   // Line r-1: current pixel replaces the previous line's pixel at the same column.
   median_line_buffer #(
      .DW    (DW),
      .DEPTH (IMG_W),
      .AW    (CW)
   ) u_buf_a (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept),
      .wr_addr (pix_col),
      .wr_data (in_data),
      .rd_en   (accept),
      .rd_addr (pix_col),
      .rd_data (line_a)
   );

   // Line r-2: receives line A's old word one cycle later, once it has been read out.
   median_line_buffer #(
      .DW    (DW),
      .DEPTH (IMG_W),
      .AW    (CW)
   ) u_buf_b (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (s1_valid),
      .wr_addr (s1_col),
      .wr_data (line_a),
      .rd_en   (accept),
      .rd_addr (pix_col),
      .rd_data (line_b)
   );

   // Stage 1: carry the pixel and its coordinates alongside the line-buffer read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sof   <= 1'b0;
         s1_row   <= '0;
         s1_col   <= '0;
         s1_data  <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_sof  <= in_sof;
            s1_row  <= pix_row;
            s1_col  <= pix_col;
            s1_data <= in_data;
         end
      end
   end

   assign col0   = {line_b, line_a, s1_data};
   assign top_ok = (s1_row >= RW'(2));
   assign mid_ok = (s1_row != '0);
   assign c1_ok  = (s1_col != '0);
   assign c2_ok  = (s1_col >= CW'(2));

   function automatic logic [DW-1:0] tap(input logic ok, input logic [DW-1:0] v);
      return ok ? v : '0;
   endfunction

   // Stage 2: shift columns and register the masked window; rows never borrow the previous line's tail.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col1        <= '0;
         col2        <= '0;
         out_valid   <= 1'b0;
         out_sof     <= 1'b0;
         out_border  <= 1'b0;
         out_row_top <= '0;
         out_row_mid <= '0;
         out_row_bot <= '0;
      end else begin
         out_valid <= s1_valid;
         out_sof   <= s1_valid && s1_sof;
         if (s1_valid) begin
            col2        <= col1;
            col1        <= col0;
            out_border  <= !top_ok || !c2_ok;
            out_row_top <= {tap(top_ok && c2_ok, col2[2]),
                            tap(top_ok && c1_ok, col1[2]),
                            tap(top_ok, col0[2])};
            out_row_mid <= {tap(mid_ok && c2_ok, col2[1]),
                            tap(mid_ok && c1_ok, col1[1]),
                            tap(mid_ok, col0[1])};
            out_row_bot <= {tap(c2_ok, col2[0]),
                            tap(c1_ok, col1[0]),
                            col0[0]};
         end
      end
   end

endmodule

// File: tb/tb_median_window_3x3.sv
// Directed bench for median_window_3x3 on a 4x4 image, pixel(r,c) = offset + 16r + c.
module tb_median_window_3x3;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_sof;
   logic [7:0]  in_data;
   logic        out_valid;
   logic        out_sof;
   logic        out_border;
   logic [23:0] out_row_top;
   logic [23:0] out_row_mid;
   logic [23:0] out_row_bot;

   median_window_3x3 #(
      .DW    (8),
      .IMG_W (4),
      .IMG_H (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_sof      (in_sof),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_sof     (out_sof),
      .out_border  (out_border),
      .out_row_top (out_row_top),
      .out_row_mid (out_row_mid),
      .out_row_bot (out_row_bot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic        sof;
      logic        border;
      logic [23:0] top;
      logic [23:0] mid;
      logic [23:0] bot;
      int          idx;
   } exp_t;

   exp_t        q[$];
   int          cycle;
   int          checks;
   int          errors;
   logic [23:0] obs_top [16];
   logic [23:0] obs_mid [16];
   logic [23:0] obs_bot [16];
   logic [15:0] obs_border;

   function automatic logic [7:0] px(input int off, input int r, input int c);
      if (r < 0 || c < 0) return 8'h00;
      return 8'(off + 16 * r + c);
   endfunction

   function automatic exp_t mk(input int off, input int r, input int c, input logic sof,
                               input int due, input int idx);
      exp_t e;
      e.due    = due;
      e.sof    = sof;
      e.border = (r < 2) || (c < 2);
      e.top    = {px(off, r - 2, c - 2), px(off, r - 2, c - 1), px(off, r - 2, c)};
      e.mid    = {px(off, r - 1, c - 2), px(off, r - 1, c - 1), px(off, r - 1, c)};
      e.bot    = {px(off, r, c - 2), px(off, r, c - 1), px(off, r, c)};
      e.idx    = idx;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cycle);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_valid", 24'(out_valid), 24'h0);
      chk("rst_sof", 24'(out_sof), 24'h0);
      chk("rst_border", 24'(out_border), 24'h0);
      chk("rst_top", out_row_top, 24'h0);
      chk("rst_mid", out_row_mid, 24'h0);
      chk("rst_bot", out_row_bot, 24'h0);
   endtask

   // Advance one clock and check the outputs against the next due window, if any.
   task automatic tick();
      exp_t e;
      logic ev;
      @(posedge clk);
      #1;
      cycle++;
      ev = (q.size() != 0) && (q[0].due == cycle);
      chk("out_valid", 24'(out_valid), 24'(ev));
      if (ev) begin
         e = q.pop_front();
         chk("out_sof", 24'(out_sof), 24'(e.sof));
         chk("out_border", 24'(out_border), 24'(e.border));
         chk("row_top", out_row_top, e.top);
         chk("row_mid", out_row_mid, e.mid);
         chk("row_bot", out_row_bot, e.bot);
         if (e.idx >= 0) begin
            obs_top[e.idx]    = out_row_top;
            obs_mid[e.idx]    = out_row_mid;
            obs_bot[e.idx]    = out_row_bot;
            obs_border[e.idx] = out_border;
         end
      end
   endtask

   task automatic send(input int off, input int r, input int c, input logic sof, input int idx);
      in_valid = 1'b1;
      in_sof   = sof;
      in_data  = px(off, r, c);
      q.push_back(mk(off, r, c, sof, cycle + 2, idx));
      tick();
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic junk(input logic [7:0] d);
      in_valid = 1'b1;
      in_sof   = 1'b0;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      cycle      = 0;
      checks     = 0;
      errors     = 0;
      obs_border = '0;
      for (int i = 0; i < 16; i++) begin
         obs_top[i] = '0;
         obs_mid[i] = '0;
         obs_bot[i] = '0;
      end
      rst      = 1'b1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_data  = 8'h00;

      // Reset state.
      #2;
      chk_reset_outputs();
      tick();
      tick();
      #3;
      rst = 1'b0;
      tick();

      // Pixels before any sof, and a lone sof without valid, are dropped.
      junk(8'hAA);
      junk(8'h55);
      in_sof = 1'b1;
      tick();
      in_sof = 1'b0;
      junk(8'h77);
      tick();

      // Frame A: continuous, recorded for hand-computed checks.
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            send(0, r, c, (r == 0 && c == 0), r * 4 + c);
         end
      end
      tick();
      tick();
      chk("win22_top", obs_top[10], 24'h000102);
      chk("win22_mid", obs_mid[10], 24'h101112);
      chk("win22_bot", obs_bot[10], 24'h202122);
      chk("win10_top", obs_top[4], 24'h000000);
      chk("win10_mid", obs_mid[4], 24'h000000);
      chk("win10_bot", obs_bot[4], 24'h000010);
      chk("win33_top", obs_top[15], 24'h111213);
      chk("win33_bot", obs_bot[15], 24'h313233);
      chk("border_map", 24'(obs_border), 24'h0033FF);

      // Pixels after the last one of the frame without sof are dropped.
      junk(8'h01);
      junk(8'h02);
      junk(8'h03);
      tick();

      // Frame B: same frame with an idle cycle after every pixel.
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            send(0, r, c, (r == 0 && c == 0), -1);
            tick();
         end
      end
      tick();

      // Frame C abandoned at (2,1) by a new sof; frame D runs to completion.
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (r * 4 + c <= 8) send(8'h40, r, c, (r == 0 && c == 0), -1);
         end
      end
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            send(8'h80, r, c, (r == 0 && c == 0), -1);
         end
      end
      tick();
      tick();

      // Frame E interrupted by an asynchronous reset mid-row 2.
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (r * 4 + c <= 9) send(8'hC0, r, c, (r == 0 && c == 0), -1);
         end
      end
      #3;
      rst = 1'b1;
      #1;
      chk_reset_outputs();
      q.delete();
      tick();
      #3;
      rst = 1'b0;
      tick();
      junk(8'h11);
      junk(8'h22);
      tick();

      // Frame F: full frame after the reset.
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            send(8'h40, r, c, (r == 0 && c == 0), -1);
         end
      end
      tick();
      tick();
      tick();
      chk("queue_empty", 24'(q.size()), 24'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/median_window_3x3.md
Name: median_window_3x3

Overview:
- Upstream stage of the median-filter path.
- Accepts a raster-order 8-bit pixel stream and holds the two previous image lines in on-chip line buffers.
- Emits, per accepted pixel, a 3x3 neighbourhood as three packed rows (top/mid/bottom, each left/centre/right).
- Those rows feed three row-wise 3-input sorters directly.

Parameters:
- DW, 8, pixel width in bits
- IMG_W, 640, pixels per line (>=3)
- IMG_H, 480, lines per frame (>=3)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  pixel qualifier
- in_sof  in  1  start of frame; meaningful only with in_valid; marks pixel (0,0)
- in_data  in  DW  pixel value
- out_valid  out  1  window qualifier
- out_sof  out  1  window belongs to pixel (0,0)
- out_border  out  1  window overlaps outside the image
- out_row_top  out  3*DW  {left, centre, right}; pixels (r-2, c-2..c)
- out_row_mid  out  3*DW  same layout; pixels (r-1, c-2..c)
- out_row_bot  out  3*DW  same layout; pixels (r, c-2..c)

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-high, port rst.
  - All outputs reset to 0.
  - FSM resets to IDLE; row/col counters reset to 0.
  - Window registers reset to 0. Line-buffer RAM contents are not reset.
- FSM states and transitions:
  - IDLE: in_valid&&in_sof goes to ACTIVE, taking pixel (0,0). Other in_valid pixels are dropped (no out_valid).
  - ACTIVE: every in_valid pixel is accepted. col increments; at IMG_W-1 it wraps to 0 and row increments. Accepting (IMG_H-1, IMG_W-1) goes to DONE.
  - DONE: pixels without sof are dropped; in_valid&&in_sof goes to ACTIVE at (0,0).
  - in_sof with in_valid in ACTIVE (mid-frame) restarts at (0,0) immediately. The partial frame is abandoned; stale line-buffer data is masked by the border rule.
  - in_sof without in_valid is ignored.
- Latency:
  - Accepted pixel at cycle t gives out_valid=1 at t+2, exactly one cycle per accepted pixel, independent of input gaps.
  - out_valid=0 on all other cycles. Outputs hold their last value while out_valid=0.
- Pipeline:
  - Stage 1: line-buffer read at address col (read-before-write). Buffer A returns line r-1; buffer B returns line r-2. Current pixel is written to A; A's old data is written to B.
  - Stage 2: three column shift registers shift only when the stage-1 valid is set. Right column = {B out, A out, in_data}.
- Masking:
  - Taps outside the image are forced to 0: rows r-1/r-2 when r<1/r<2; columns c-1/c-2 when c<1/c<2.
  - out_border=1 iff r<2 or c<2.
  - Columns never wrap across lines: the left taps at c=0/1 are masked, not taken from the previous line.
- out_sof=1 only together with out_valid, for pixel (0,0).
- Reset mid-frame: in-flight pixels are discarded; no out_valid after rst deasserts until the next sof pixel has been accepted.
- Width: counters are clog2(IMG_W) and clog2(IMG_H) bits. No arithmetic on pixel data.

Decomposition:
- Shared package holds:
  - DW default
  - the window type (3x3 array of DW)
  - the FSM state enum {IDLE, ACTIVE, DONE}
  - the LATENCY=2 constant, also used by the downstream sort stage to align sideband signals
- Sub-module median_line_buffer: simple dual-port RAM, depth IMG_W, width DW, registered read, read-before-write on same address. Instantiated twice.

Test Plan (IMG_W=4, IMG_H=4, pixel(r,c)=16r+c):
- Continuous frame, sof on first pixel → 16 out_valid pulses, each 2 cycles after its input. out_border=1 for the first 8 windows plus (2,0),(2,1),(3,0),(3,1). Window at (2,2): top={00,01,02}, mid={10,11,12}, bot={20,21,22}, border=0.
- Same frame with one idle cycle after every pixel → identical window sequence. Each out_valid still exactly 2 cycles after its pixel.
- Window at (1,0) → top, mid-left, mid-centre and bot-left/centre taps are 0, bot-right=0x10, mid-right=0x00, border=1. Confirms no wrap from line 0's last pixels.
- Pixels sent before any sof, and pixels after (3,3) without sof → no out_valid. Next sof frame → output restarts with out_sof=1.
- sof reasserted at pixel (2,1) → that pixel is treated as (0,0) with out_sof=1. Next 8 windows have border=1. Windows from row 2 on contain only new-frame data.
- rst pulsed asynchronously mid-row 2 → all outputs 0 within the reset. No out_valid until a new sof pixel is accepted; then a correct full frame.
